// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file's single write port,
// plus a per-register busy scoreboard for read-after-write hazard detection.
module regfile_wb_arbiter #(
  parameter int unsigned N     = 64,
  parameter int unsigned R     = 32,
  parameter int unsigned ASIZE = $clog2(R),
  parameter int unsigned NREQ  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ASIZE-1:0]      req_id,
  input  logic [NREQ*N-1:0]          req_data,
  input  logic                       hold,
  input  logic                       alloc_valid,
  input  logic [ASIZE-1:0]           alloc_id,
  output logic                       alloc_ready,
  output logic                       wr,
  output logic [ASIZE-1:0]           reg_id_w,
  output logic [N-1:0]               data_in,
  output logic [R-1:0]               busy,
  output logic [$clog2(NREQ)-1:0]    grant_idx
);

  localparam int unsigned GW = $clog2(NREQ);

  logic [GW-1:0] ptr;
  logic [GW-1:0] cand;
  logic [GW-1:0] win_idx;
  logic          found;
  logic          xfer;
  logic [R-1:0]  busy_nxt;

  // Search from ptr upward; GW-bit arithmetic wraps modulo NREQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = ptr + GW'(k);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign xfer        = rst & ~hold & found;
  assign req_ready   = xfer ? (NREQ'(1) << win_idx) : '0;
  assign alloc_ready = rst & ~busy[alloc_id];

  // Commit clears first so a same-edge reservation of that register wins.
  always_comb begin
    busy_nxt = busy;
    if (wr) begin
      busy_nxt[reg_id_w] = 1'b0;
    end
    if (alloc_valid && alloc_ready) begin
      busy_nxt[alloc_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr        <= 1'b0;
      reg_id_w  <= '0;
      data_in   <= '0;
      grant_idx <= '0;
      busy      <= '0;
      ptr       <= '0;
    end else begin
      wr   <= xfer;
      busy <= busy_nxt;
      if (xfer) begin
        reg_id_w  <= req_id[int'(win_idx)*ASIZE +: ASIZE];
        data_in   <= req_data[int'(win_idx)*N +: N];
        grant_idx <= win_idx;
        ptr       <= win_idx + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;

  localparam int unsigned N     = 64;
  localparam int unsigned R     = 32;
  localparam int unsigned ASIZE = 5;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned GW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*ASIZE-1:0] req_id;
  logic [NREQ*N-1:0]     req_data;
  logic                  hold;
  logic                  alloc_valid;
  logic [ASIZE-1:0]      alloc_id;
  logic                  alloc_ready;
  logic                  wr;
  logic [ASIZE-1:0]      reg_id_w;
  logic [N-1:0]          data_in;
  logic [R-1:0]          busy;
  logic [GW-1:0]         grant_idx;

  int total = 0;
  int bad   = 0;

  // Model state: pointer, scoreboard and the write sitting on the output port.
  int              m_ptr  = 0;
  bit [R-1:0]      m_busy = '0;
  bit              m_wr   = 1'b0;
  bit [ASIZE-1:0]  m_id   = '0;
  bit [N-1:0]      m_data = '0;
  int              m_gidx = 0;

  regfile_wb_arbiter #(.N(N), .R(R), .ASIZE(ASIZE), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_data(req_data), .hold(hold),
    .alloc_valid(alloc_valid), .alloc_id(alloc_id), .alloc_ready(alloc_ready),
    .wr(wr), .reg_id_w(reg_id_w), .data_in(data_in), .busy(busy),
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  function automatic int m_winner();
    if (!rst || hold) return -1;
    for (int k = 0; k < int'(NREQ); k++) begin
      int i;
      i = (m_ptr + k) % int'(NREQ);
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit [NREQ-1:0] m_ready();
    bit [NREQ-1:0] r;
    int w;
    r = '0;
    w = m_winner();
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic bit m_alloc_ready();
    return rst && !m_busy[alloc_id];
  endfunction

  // Advance one clock edge, updating the model from the inputs seen at it.
  task automatic tick();
    int w;
    bit [R-1:0] nb;
    bit ar;
    w  = m_winner();
    ar = m_alloc_ready();
    @(posedge clk);
    if (!rst) begin
      m_ptr = 0; m_busy = '0; m_wr = 1'b0; m_id = '0; m_data = '0; m_gidx = 0;
    end else begin
      nb = m_busy;
      if (m_wr) nb[m_id] = 1'b0;
      if (alloc_valid && ar) nb[alloc_id] = 1'b1;
      m_busy = nb;
      m_wr = (w >= 0);
      if (w >= 0) begin
        m_id   = req_id[w*ASIZE +: ASIZE];
        m_data = req_data[w*N +: N];
        m_gidx = w;
        m_ptr  = (w + 1) % int'(NREQ);
      end
    end
    #1;
  endtask

  task automatic rand_payload();
    req_id = (NREQ*ASIZE)'($urandom);
    for (int i = 0; i < int'(NREQ); i++) req_data[i*N +: N] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b0; hold = 1'b0; req_valid = '1; alloc_valid = 1'b1; alloc_id = 5'd7;
    rand_payload();
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
      total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL reset_alloc_ready got=%b exp=0", alloc_ready); end
      total++; if (wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", wr); end
      total++; if (busy !== '0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    end
    rst = 1'b1; alloc_valid = 1'b0; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    tick();
    total++; if (wr !== 1'b1 || grant_idx !== 2'd0) begin bad++; $display("FAIL reset_first_wr got wr=%b idx=%0d exp wr=1 idx=0", wr, grant_idx); end
    req_valid = '0; tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_id[2*ASIZE +: ASIZE] = 5'd5;
    req_data[2*N +: N] = 64'hDEAD_BEEF;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    total++; if (wr !== 1'b1 || reg_id_w !== 5'd5 || data_in !== 64'hDEAD_BEEF || grant_idx !== 2'd2)
      begin bad++; $display("FAIL single_write got wr=%b id=%0d data=%h idx=%0d exp wr=1 id=5 data=deadbeef idx=2", wr, reg_id_w, data_in, grant_idx); end
    tick();
    total++; if (wr !== 1'b0 || reg_id_w !== 5'd5) begin bad++; $display("FAIL single_idle got wr=%b id=%0d exp wr=0 id=5", wr, reg_id_w); end
  endtask

  task automatic test_round_robin();
    int seq2 [4] = '{0, 2, 3, 0};
    req_valid = 4'b1000; #1; tick();
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      rand_payload(); #1;
      total++; if (req_ready !== 4'(1 << (c % 4))) begin bad++; $display("FAIL rr_ready c=%0d got=%b exp_idx=%0d", c, req_ready, c % 4); end
      tick();
      total++; if (wr !== 1'b1 || grant_idx !== 2'(c % 4) || data_in !== m_data)
        begin bad++; $display("FAIL rr_grant c=%0d got wr=%b idx=%0d data=%h exp idx=%0d data=%h", c, wr, grant_idx, data_in, c % 4, m_data); end
    end
    req_valid = 4'b1101;
    for (int c = 0; c < 4; c++) begin
      rand_payload(); tick();
      total++; if (wr !== 1'b1 || grant_idx !== 2'(seq2[c])) begin bad++; $display("FAIL rr_dropout c=%0d got wr=%b idx=%0d exp idx=%0d", c, wr, grant_idx, seq2[c]); end
    end
    req_valid = '0; tick();
  endtask

  task automatic test_hold();
    req_valid = 4'b1010; hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL hold_ready c=%0d got=%b exp=0000", c, req_ready); end
      tick();
      total++; if (wr !== 1'b0) begin bad++; $display("FAIL hold_wr c=%0d got=%b exp=0", c, wr); end
    end
    hold = 1'b0; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL hold_resume got=%b exp=0010", req_ready); end
    tick(); #1;
    total++; if (grant_idx !== 2'd1 || req_ready !== 4'b1000) begin bad++; $display("FAIL hold_next got idx=%0d ready=%b exp idx=1 ready=1000", grant_idx, req_ready); end
    tick();
    req_valid = '0; tick();
  endtask

  task automatic test_scoreboard();
    alloc_valid = 1'b1; alloc_id = 5'd7; #1;
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL sb_alloc_ready got=%b exp=1", alloc_ready); end
    tick();
    alloc_valid = 1'b0; #1;
    total++; if (busy[7] !== 1'b1 || alloc_ready !== 1'b0) begin bad++; $display("FAIL sb_reserved got busy7=%b ardy=%b exp busy7=1 ardy=0", busy[7], alloc_ready); end
    req_valid = 4'b0001; req_id[0 +: ASIZE] = 5'd7; tick();
    req_valid = '0;
    total++; if (busy[7] !== 1'b1 || wr !== 1'b1) begin bad++; $display("FAIL sb_t1 got busy7=%b wr=%b exp busy7=1 wr=1", busy[7], wr); end
    tick();
    total++; if (busy[7] !== 1'b0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL sb_t2 got busy7=%b ardy=%b exp busy7=0 ardy=1", busy[7], alloc_ready); end
    req_valid = 4'b0001; tick();
    req_valid = '0; alloc_valid = 1'b1; #1;
    total++; if (wr !== 1'b1 || reg_id_w !== 5'd7 || alloc_ready !== 1'b1) begin bad++; $display("FAIL sb_setclr_pre got wr=%b id=%0d ardy=%b exp 1 7 1", wr, reg_id_w, alloc_ready); end
    tick();
    alloc_valid = 1'b0;
    total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL sb_set_wins got busy7=%b exp=1", busy[7]); end
    tick();
    total++; if (busy[7] !== 1'b1 || busy !== m_busy) begin bad++; $display("FAIL sb_persist got busy=%h exp=%h", busy, m_busy); end
  endtask

  task automatic test_reset_mid();
    alloc_valid = 1'b1; alloc_id = 5'd3; tick();
    alloc_valid = 1'b0;
    req_valid = 4'b0001; req_id[0 +: ASIZE] = 5'd3; req_data[0 +: N] = 64'h1234_5678_9ABC_DEF0; tick();
    req_valid = '0; rst = 1'b0;
    total++; if (wr !== 1'b1 || busy[3] !== 1'b1) begin bad++; $display("FAIL rmid_pending got wr=%b busy3=%b exp 1 1", wr, busy[3]); end
    tick();
    total++; if (wr !== 1'b0 || busy !== '0 || reg_id_w !== '0 || data_in !== '0)
      begin bad++; $display("FAIL rmid_reset got wr=%b busy=%h id=%0d data=%h exp all 0", wr, busy, reg_id_w, data_in); end
    rst = 1'b1; tick();
    total++; if (wr !== 1'b0) begin bad++; $display("FAIL rmid_discard got wr=%b exp=0", wr); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid   = 4'($urandom);
      hold        = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 49) != 0);
      alloc_valid = ($urandom_range(0, 2) == 0);
      alloc_id    = 5'($urandom);
      rand_payload(); #1;
      total++; if (req_ready !== m_ready() || alloc_ready !== m_alloc_ready())
        begin bad++; $display("FAIL rand_ready c=%0d got=%b/%b exp=%b/%b", c, req_ready, alloc_ready, m_ready(), m_alloc_ready()); end
      tick();
      total++; if (wr !== m_wr || busy !== m_busy || reg_id_w !== m_id || data_in !== m_data || grant_idx !== 2'(m_gidx))
        begin bad++; $display("FAIL rand_state c=%0d got wr=%b id=%0d idx=%0d busy=%h exp wr=%b id=%0d idx=%0d busy=%h", c, wr, reg_id_w, grant_idx, busy, m_wr, m_id, m_gidx, m_busy); end
    end
    rst = 1'b1; req_valid = '0; hold = 1'b0; alloc_valid = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_id = '0; req_data = '0;
    hold = 1'b0; alloc_valid = 1'b0; alloc_id = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and scoreboard for the 32 x 64b register file's single write port. Up to NREQ writeback sources (ALU, load unit, etc.) compete for the port under round-robin arbitration. The winner is registered onto the register file's wr/reg_id_w/data_in inputs. A per-register busy scoreboard tracks destinations reserved at issue and cleared when the write commits, so the issue stage can detect read-after-write hazards.

## Interface
- N, 64, data width per register
- R, 32, number of architectural registers
- ASIZE, $clog2(R), register address width
- NREQ, 4, number of writeback requesters (power of two, >= 2)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset: sampled on posedge clk, 0 = reset
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant; combinational
- req_id  in  NREQ*ASIZE  destination ids, requester i at bits [i*ASIZE +: ASIZE]
- req_data  in  NREQ*N  write data, requester i at bits [i*N +: N]
- hold  in  1  pipeline freeze; blocks all grants while 1
- alloc_valid  in  1  issue stage reserves destination alloc_id
- alloc_id  in  ASIZE  register being reserved
- alloc_ready  out  1  reservation accepted; combinational
- wr  out  1  register-file write enable (registered)
- reg_id_w  out  ASIZE  register-file write address (registered)
- data_in  out  N  register-file write data (registered)
- busy  out  R  scoreboard; bit k = 1 while register k has an outstanding write
- grant_idx  out  $clog2(NREQ)  index of the requester whose write is currently on wr (registered)

## Operation
- Arbitration: round-robin with priority pointer ptr (reset 0).
  - Search order is ptr, ptr+1, …, ptr+NREQ-1 (mod NREQ).
  - The first i with req_valid[i]=1 wins.
  - req_ready[i]=1 only for the winner, and only when rst=1 and hold=0.
  - At most one req_ready bit is high per cycle.
- Handshake: transfer happens when req_valid[i] & req_ready[i] at posedge.
  - A requester holds valid/id/data stable until accepted.
  - Deasserting valid before acceptance is permitted; the request is withdrawn.
- On transfer from requester g:
  - Next cycle: wr=1, reg_id_w=req_id[g], data_in=req_data[g], grant_idx=g.
  - ptr <= (g+1) mod NREQ.
- With no transfer (nothing valid, or hold=1): next cycle wr=0, ptr unchanged, reg_id_w/data_in/grant_idx hold their last values.
- Output stage never stalls; the register file consumes one write per cycle.
- Two requesters may target the same register; the writes are committed in grant order with no merging.
- Scoreboard:
  - alloc_ready = rst & ~busy[alloc_id].
  - On alloc_valid & alloc_ready at posedge: busy[alloc_id] <= 1.
  - On posedge with wr=1: busy[reg_id_w] <= 0 (write commits at that edge).
  - Same edge, same register, set and clear: set wins, busy stays 1.
  - Clear of a non-busy register is a no-op.
  - Writes are accepted regardless of busy state.
- Reset (rst=0 at posedge): wr=0, reg_id_w=0, data_in=0, grant_idx=0, busy=0, ptr=0.
  - While rst=0, req_ready=0 and alloc_ready=0.
  - Reset mid-operation discards any write pending in the output stage; it is never committed.

## Timing
- Accept-to-wr latency: 1 cycle. wr is high in the cycle after the accepting edge. The register file stores the write at the following edge.
- busy[k] clears at the commit edge, so it is first low 2 cycles after acceptance.
- A register-file read of k issued while busy[k]=1 returns the old value.
- Throughput: 1 write/cycle sustained. With all NREQ valid, each requester is granted once every NREQ cycles.
- req_ready and alloc_ready have a combinational path from req_valid/hold/rst and busy/alloc_id respectively. No combinational path reaches wr/reg_id_w/data_in/busy/grant_idx.

## Test plan
- Reset:
  - Stimulus: hold rst=0 for 2 cycles with all req_valid=1 and alloc_valid=1.
  - Required: req_ready=0, alloc_ready=0, wr=0, busy=0. After release, the first grant goes to requester 0.
- Single write:
  - Stimulus: requester 2 sends id=5, data=64'hDEAD_BEEF at cycle t.
  - Required: req_ready[2]=1 at t; wr=1, reg_id_w=5, data_in=DEAD_BEEF, grant_idx=2 at t+1; wr=0 at t+2.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously from ptr=0.
  - Required: grant order 0,1,2,3,0,… with wr=1 every cycle. With requester 1 dropping out, order becomes 0,2,3,0.
- Hold:
  - Stimulus: assert hold for 3 cycles with requesters 1 and 3 valid.
  - Required: no req_ready and wr=0 during hold, ptr unchanged. First grant after hold follows the pre-hold pointer.
- Scoreboard:
  - Stimulus: alloc id=7, then a request to id 7 is accepted at t.
  - Required: busy[7]=1 through t+1, 0 at t+2; alloc_ready=0 for id 7 while busy.
  - Stimulus: alloc id=7 on the same edge as the commit to 7.
  - Required: busy[7] stays 1.
- Reset mid-operation:
  - Stimulus: accept a write to id 3 at t, drive rst=0 at t+1.
  - Required: busy=0 and wr=0 after that edge; register 3 is unchanged.
